// File: rtl/llc_pkg.sv
// Shared types for the LLC request front-end: command codes,
// sequencer states and command legality helpers.
package llc_pkg;

    localparam int CMD_W = 4;

    typedef enum logic [CMD_W-1:0] {
        RD_L1D   = 4'd0,
        WR_L1D   = 4'd1,
        RD_L1I   = 4'd2,
        SNP_INV  = 4'd3,
        SNP_RD   = 4'd4,
        SNP_WR   = 4'd5,
        SNP_RWIM = 4'd6,
        CLR      = 4'd8,
        PRINT    = 4'd9
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    function automatic logic is_l1_cmd(input logic [CMD_W-1:0] c);
        logic ok;
        case (c)
            RD_L1D, WR_L1D, RD_L1I, CLR, PRINT: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_snp_cmd(input logic [CMD_W-1:0] c);
        logic ok;
        case (c)
            SNP_INV, SNP_RD, SNP_WR, SNP_RWIM: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Clear/print must never overtake a snoop already held.
    function automatic logic is_ordered_cmd(input logic [CMD_W-1:0] c);
        return (c == CLR) || (c == PRINT);
    endfunction

endpackage

// File: rtl/llc_req_fifo.sv
// Synchronous FIFO with extra-MSB pointers; no pass-through,
// so a full FIFO refuses a push even on the edge it pops.
module llc_req_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign empty = (r_wptr == r_rptr);
    assign count = CW'(r_wptr - r_rptr);
    assign rdata = r_mem[r_rptr[AW-1:0]];

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/llc_req_sequencer.sv
// Front-end scheduler for the LLC: arbitrates snoops against buffered
// L1 requests and keeps exactly one command in flight at a time.
module llc_req_sequencer
    import llc_pkg::*;
#(
    parameter int ADDR_BITS    = 32,
    parameter int CMDSIZE      = 4,
    parameter int L1_DEPTH     = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          l1_valid,
    output logic                          l1_ready,
    input  logic [CMDSIZE-1:0]            l1_cmd,
    input  logic [ADDR_BITS-1:0]          l1_addr,
    input  logic                          snp_valid,
    output logic                          snp_ready,
    input  logic [CMDSIZE-1:0]            snp_cmd,
    input  logic [ADDR_BITS-1:0]          snp_addr,
    output logic                          llc_valid,
    input  logic                          llc_ready,
    output logic [CMDSIZE-1:0]            llc_cmd,
    output logic [ADDR_BITS-1:0]          llc_addr,
    input  logic                          llc_done,
    output logic                          grant_snp,
    output logic                          busy,
    output logic [$clog2(L1_DEPTH+1)-1:0] l1_count,
    output logic                          err_illegal
);

    localparam int PW = CMDSIZE + ADDR_BITS;
    localparam int CW = $clog2(L1_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    seq_state_t           r_state;
    logic                 r_llc_valid;
    logic [CMDSIZE-1:0]   r_llc_cmd;
    logic [ADDR_BITS-1:0] r_llc_addr;
    logic                 r_grant_snp;
    logic                 r_busy;
    logic                 r_err;
    logic [SW-1:0]        r_starve_cnt;

    logic                 r_snp_held;
    logic [CMDSIZE-1:0]   r_snp_cmd;
    logic [ADDR_BITS-1:0] r_snp_addr;

    logic                 w_full;
    logic                 w_empty;
    logic [CW-1:0]        w_count;
    logic [PW-1:0]        w_head;
    logic [CMDSIZE-1:0]   w_head_cmd;
    logic [ADDR_BITS-1:0] w_head_addr;

    logic                 w_l1_hs;
    logic                 w_l1_legal;
    logic                 w_fifo_push;
    logic                 w_snp_hs;
    logic                 w_snp_legal;

    logic                 w_starved;
    logic                 w_pick_l1;
    logic                 w_grant;
    logic                 w_grant_l1;
    logic                 w_grant_snp;

    assign w_l1_hs     = l1_valid && !w_full;
    assign w_l1_legal  = is_l1_cmd(l1_cmd);
    assign w_fifo_push = w_l1_hs && w_l1_legal;

    assign w_snp_hs    = snp_valid && !r_snp_held;
    assign w_snp_legal = is_snp_cmd(snp_cmd);

    llc_req_fifo #(
        .WIDTH (PW),
        .DEPTH (L1_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_fifo_push),
        .wdata ({l1_cmd, l1_addr}),
        .pop   (w_grant_l1),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_head_cmd  = w_head[PW-1:ADDR_BITS];
    assign w_head_addr = w_head[ADDR_BITS-1:0];

    // L1 wins only when forced by starvation, and never for an
    // ordered command while a snoop is held.
    assign w_starved   = (r_starve_cnt == STARVE_MAX) && !w_empty;
    assign w_pick_l1   = !w_empty &&
                         (!r_snp_held ||
                          (w_starved && !is_ordered_cmd(w_head_cmd)));
    assign w_grant     = (r_state == IDLE) && (r_snp_held || !w_empty);
    assign w_grant_l1  = w_grant && w_pick_l1;
    assign w_grant_snp = w_grant && !w_pick_l1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snp_held <= 1'b0;
            r_snp_cmd  <= '0;
            r_snp_addr <= '0;
        end else if (w_grant_snp) begin
            r_snp_held <= 1'b0;
        end else if (w_snp_hs && w_snp_legal) begin
            r_snp_held <= 1'b1;
            r_snp_cmd  <= snp_cmd;
            r_snp_addr <= snp_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (w_l1_hs && !w_l1_legal) ||
                     (w_snp_hs && !w_snp_legal);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_empty || w_grant_l1) begin
            r_starve_cnt <= '0;
        end else if (w_grant_snp && (r_starve_cnt != STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_llc_valid <= 1'b0;
            r_llc_cmd   <= '0;
            r_llc_addr  <= '0;
            r_grant_snp <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state     <= ISSUE;
                        r_llc_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_grant_snp <= !w_pick_l1;
                        r_llc_cmd   <= w_pick_l1 ? w_head_cmd : r_snp_cmd;
                        r_llc_addr  <= w_pick_l1 ? w_head_addr : r_snp_addr;
                    end
                end
                ISSUE: begin
                    if (llc_ready) begin
                        r_state     <= WAIT;
                        r_llc_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (llc_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_llc_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign l1_ready    = !w_full;
    assign snp_ready   = !r_snp_held;
    assign llc_valid   = r_llc_valid;
    assign llc_cmd     = r_llc_cmd;
    assign llc_addr    = r_llc_addr;
    assign grant_snp   = r_grant_snp;
    assign busy        = r_busy;
    assign l1_count    = w_count;
    assign err_illegal = r_err;

endmodule
